// File: rtl/tcdm_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tcdm_rr_arbiter
//   Round-robin arbiter that funnels NUM_MASTERS TCDM masters onto one shared
//   TCDM slave. The slave returns responses exactly one cycle after each
//   accepted request.
//
//   Optional feature macro: TCDM_ARB_ERR_CNT_EN
//     defined   -> err_cnt_o counts error responses (s_r_opc_i=1 on a routed
//                  response) and saturates at 16'hFFFF
//     undefined -> err_cnt_o is tied to 0 and no counter is built
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   m_req_i / m_wen_i         per-master request and write-enable (1 = read)
//   m_add_i/m_wdata_i/m_be_i  per-master payload (packed per master)
//   m_gnt_o / m_r_valid_o     per-master grant and response valid
//   m_r_rdata_o / m_r_opc_o   response data / error flag, broadcast
//   s_req_o ... s_be_o        request to the shared slave (winner payload)
//   s_gnt_i, s_r_valid_i,
//   s_r_rdata_i, s_r_opc_i    slave grant and response
//   err_cnt_o                 error-response counter
// -----------------------------------------------------------------------------

// Per-master grant / response-valid decode.
module tcdm_rr_arbiter_lane #(
    parameter int IDX_W   = 2,
    parameter int LANE_ID = 0
) (
    input  logic [IDX_W-1:0] i_winner,
    input  logic             i_gnt,
    input  logic [IDX_W-1:0] i_rsp_id,
    input  logic             i_rsp_vld,
    output logic             o_gnt,
    output logic             o_r_valid
);
    localparam logic [IDX_W-1:0] ID = IDX_W'(LANE_ID);

    assign o_gnt     = i_gnt     & (i_winner == ID);
    assign o_r_valid = i_rsp_vld & (i_rsp_id == ID);
endmodule

module tcdm_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NUM_MASTERS-1:0]                  m_req_i,
    input  logic [NUM_MASTERS-1:0]                  m_wen_i,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  m_add_i,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  m_wdata_i,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] m_be_i,
    output logic [NUM_MASTERS-1:0]                  m_gnt_o,
    output logic [NUM_MASTERS-1:0]                  m_r_valid_o,
    output logic [DATA_WIDTH-1:0]                   m_r_rdata_o,
    output logic                                    m_r_opc_o,
    output logic                                    s_req_o,
    output logic                                    s_wen_o,
    output logic [ADDR_WIDTH-1:0]                   s_add_o,
    output logic [DATA_WIDTH-1:0]                   s_wdata_o,
    output logic [DATA_WIDTH/8-1:0]                 s_be_o,
    input  logic                                    s_gnt_i,
    input  logic                                    s_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                   s_r_rdata_i,
    input  logic                                    s_r_opc_i,
    output logic [15:0]                             err_cnt_o
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [IDX_W-1:0] r_ptr;       // highest-priority master
    logic             r_lock_vld;  // a stalled request is being held
    logic [IDX_W-1:0] r_lock_id;
    logic             r_rsp_pend;  // a handshake happened last cycle
    logic [IDX_W-1:0] r_rsp_id;

    logic [IDX_W-1:0] w_hi_idx, w_lo_idx, w_rr_winner, w_winner, w_ptr_nxt;
    logic             w_hi_found;
    logic             w_hs, w_stall, w_lane_gnt, w_rsp_vld;

    // Round-robin pick: lowest requester at/above r_ptr, else lowest overall.
    // The descending loop lets the last match win, i.e. the lowest index.
    always_comb begin
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_hi_found = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (m_req_i[i]) begin
                w_lo_idx = IDX_W'(i);
                if (IDX_W'(i) >= r_ptr) begin
                    w_hi_idx   = IDX_W'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_rr_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    // A held lock only sticks while its owner keeps requesting; if the owner
    // drops out (illegal), arbitration simply resumes.
    assign w_winner  = (r_lock_vld && m_req_i[r_lock_id]) ? r_lock_id : w_rr_winner;
    assign w_ptr_nxt = (w_winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : w_winner + 1'b1;

    assign s_req_o   = |m_req_i;
    assign s_wen_o   = m_wen_i[w_winner];
    assign s_add_o   = m_add_i[w_winner];
    assign s_wdata_o = m_wdata_i[w_winner];
    assign s_be_o    = m_be_i[w_winner];

    assign w_hs      = s_req_o & s_gnt_i;
    assign w_stall   = s_req_o & ~s_gnt_i;

    // Grants and response valids are held low during reset.
    assign w_lane_gnt = w_hs & ~rst_i;
    assign w_rsp_vld  = s_r_valid_i & r_rsp_pend & ~rst_i;

    assign m_r_rdata_o = s_r_rdata_i;
    assign m_r_opc_o   = s_r_opc_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr      <= '0;
            r_lock_vld <= 1'b0;
            r_lock_id  <= '0;
            r_rsp_pend <= 1'b0;
            r_rsp_id   <= '0;
        end else begin
            if (w_hs) begin
                r_ptr    <= w_ptr_nxt;
                r_rsp_id <= w_winner;
            end
            r_lock_vld <= w_stall;
            if (w_stall) begin
                r_lock_id <= w_winner;
            end
            r_rsp_pend <= w_hs;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_MASTERS; g++) begin : g_lane
            tcdm_rr_arbiter_lane #(
                .IDX_W   (IDX_W),
                .LANE_ID (g)
            ) u_lane (
                .i_winner  (w_winner),
                .i_gnt     (w_lane_gnt),
                .i_rsp_id  (r_rsp_id),
                .i_rsp_vld (w_rsp_vld),
                .o_gnt     (m_gnt_o[g]),
                .o_r_valid (m_r_valid_o[g])
            );
        end
    endgenerate

`ifdef TCDM_ARB_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_cnt <= '0;
        end else if (w_rsp_vld && s_r_opc_i && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    assign err_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    // A locked master must keep requesting until its handshake.
    a_lock_hold : assert property (@(posedge clk_i) disable iff (rst_i)
        r_lock_vld |-> m_req_i[r_lock_id]);
`endif

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
module tb_tcdm_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic               clk;
    logic               rst_i;
    logic [N-1:0]       m_req_i, m_wen_i;
    logic [N-1:0][AW-1:0]   m_add_i;
    logic [N-1:0][DW-1:0]   m_wdata_i;
    logic [N-1:0][DW/8-1:0] m_be_i;
    logic [N-1:0]       m_gnt_o, m_r_valid_o;
    logic [DW-1:0]      m_r_rdata_o;
    logic               m_r_opc_o;
    logic               s_req_o, s_wen_o;
    logic [AW-1:0]      s_add_o;
    logic [DW-1:0]      s_wdata_o;
    logic [DW/8-1:0]    s_be_o;
    logic               s_gnt_i, s_r_valid_i, s_r_opc_i;
    logic [DW-1:0]      s_r_rdata_i;
    logic [15:0]        err_cnt_o;

    int checks   = 0;
    int failures = 0;

    tcdm_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m_req_i(m_req_i), .m_wen_i(m_wen_i), .m_add_i(m_add_i),
        .m_wdata_i(m_wdata_i), .m_be_i(m_be_i),
        .m_gnt_o(m_gnt_o), .m_r_valid_o(m_r_valid_o),
        .m_r_rdata_o(m_r_rdata_o), .m_r_opc_o(m_r_opc_o),
        .s_req_o(s_req_o), .s_wen_o(s_wen_o), .s_add_o(s_add_o),
        .s_wdata_o(s_wdata_o), .s_be_o(s_be_o),
        .s_gnt_i(s_gnt_i), .s_r_valid_i(s_r_valid_i),
        .s_r_rdata_i(s_r_rdata_i), .s_r_opc_i(s_r_opc_i),
        .err_cnt_o(err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed per-master payload; master 2's address is 32'h1C00_0010.
    function automatic logic [31:0] add_of(int i);
        return 32'h1C00_0000 | (i << 3);
    endfunction
    function automatic logic [31:0] wdata_of(int i);
        return 32'hA5A5_0000 + i;
    endfunction
    function automatic logic [3:0] be_of(int i);
        return 4'(1 << i);
    endfunction

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        gnt;
        logic        rv;
        logic        opc;
        logic [31:0] rdata;
        logic        exp_sreq;
        int          exp_win;
        logic [3:0]  exp_gnt;
        logic [3:0]  exp_rv;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] req, input logic gnt,
                         input logic rv, input logic opc, input logic [31:0] rdata);
        @(negedge clk);
        rst_i       = rst;
        m_req_i     = req;
        s_gnt_i     = gnt;
        s_r_valid_i = rv;
        s_r_opc_i   = opc;
        s_r_rdata_i = rdata;
        #1;
    endtask

    task automatic chk_payload(input string tag, input int w);
        chk({tag, " s_add"},   s_add_o,          add_of(w));
        chk({tag, " s_wdata"}, s_wdata_o,        wdata_of(w));
        chk({tag, " s_be"},    32'(s_be_o),      32'(be_of(w)));
        chk({tag, " s_wen"},   32'(s_wen_o),     32'(w & 1));
    endtask

    initial begin
        rst_i = 1'b1; m_req_i = '0; s_gnt_i = 0; s_r_valid_i = 0; s_r_opc_i = 0;
        s_r_rdata_i = '0;
        for (int i = 0; i < N; i++) begin
            m_add_i[i]   = add_of(i);
            m_wdata_i[i] = wdata_of(i);
            m_be_i[i]    = be_of(i);
            m_wen_i[i]   = 1'(i & 1);
        end

        //            rst  req     gnt rv opc rdata          sreq win gnt     rv
        tbl[0]  = '{1'b1, 4'b0000, 0, 0, 0, 32'h0,         0, 0, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b1, 4'b1111, 1, 1, 0, 32'h1111_0001, 1, 0, 4'b0000, 4'b0000};
        tbl[2]  = '{1'b0, 4'b1111, 1, 0, 0, 32'h0,         1, 0, 4'b0001, 4'b0000};
        tbl[3]  = '{1'b0, 4'b1111, 1, 1, 0, 32'h0000_0003, 1, 1, 4'b0010, 4'b0001};
        tbl[4]  = '{1'b0, 4'b1111, 1, 1, 0, 32'h0000_0004, 1, 2, 4'b0100, 4'b0010};
        tbl[5]  = '{1'b0, 4'b1111, 1, 1, 0, 32'h0000_0005, 1, 3, 4'b1000, 4'b0100};
        tbl[6]  = '{1'b0, 4'b1111, 1, 1, 0, 32'h0000_0006, 1, 0, 4'b0001, 4'b1000};
        tbl[7]  = '{1'b0, 4'b1111, 1, 1, 0, 32'h0000_0007, 1, 1, 4'b0010, 4'b0001};
        tbl[8]  = '{1'b0, 4'b1111, 1, 1, 0, 32'h0000_0008, 1, 2, 4'b0100, 4'b0010};
        tbl[9]  = '{1'b0, 4'b1111, 1, 1, 0, 32'h0000_0009, 1, 3, 4'b1000, 4'b0100};
        tbl[10] = '{1'b0, 4'b0000, 1, 1, 0, 32'h0000_000A, 0, 0, 4'b0000, 4'b1000};
        // spurious response, error flag set: must not route
        tbl[11] = '{1'b0, 4'b0000, 0, 1, 1, 32'hDEAD_BEEF, 0, 0, 4'b0000, 4'b0000};
        // master 1 read with error response
        tbl[12] = '{1'b0, 4'b0010, 1, 0, 0, 32'h0,         1, 1, 4'b0010, 4'b0000};
        tbl[13] = '{1'b0, 4'b0000, 0, 1, 1, 32'hBADA_CCE5, 0, 0, 4'b0000, 4'b0010};
        // ptr=2: master 3 wins, stalls; master 2 arrives but lock holds 3
        tbl[14] = '{1'b0, 4'b1010, 0, 0, 0, 32'h0,         1, 3, 4'b0000, 4'b0000};
        tbl[15] = '{1'b0, 4'b1110, 0, 0, 0, 32'h0,         1, 3, 4'b0000, 4'b0000};
        tbl[16] = '{1'b0, 4'b1110, 1, 0, 0, 32'h0,         1, 3, 4'b1000, 4'b0000};
        tbl[17] = '{1'b0, 4'b0111, 1, 1, 0, 32'h0000_0011, 1, 0, 4'b0001, 4'b1000};
        tbl[18] = '{1'b0, 4'b0000, 0, 1, 0, 32'h0000_0012, 0, 0, 4'b0000, 4'b0001};
        tbl[19] = '{1'b0, 4'b0000, 0, 0, 0, 32'h0,         0, 0, 4'b0000, 4'b0000};

        for (int r = 0; r < 20; r++) begin
            string tag;
            tag = $sformatf("row%0d", r);
            drive(tbl[r].rst, tbl[r].req, tbl[r].gnt, tbl[r].rv, tbl[r].opc, tbl[r].rdata);
            chk({tag, " s_req"},   32'(s_req_o),     32'(tbl[r].exp_sreq));
            chk({tag, " m_gnt"},   32'(m_gnt_o),     32'(tbl[r].exp_gnt));
            chk({tag, " m_rvalid"},32'(m_r_valid_o), 32'(tbl[r].exp_rv));
            chk({tag, " m_rdata"}, m_r_rdata_o,      tbl[r].rdata);
            chk({tag, " m_opc"},   32'(m_r_opc_o),   32'(tbl[r].opc));
            if (tbl[r].exp_sreq) chk_payload(tag, tbl[r].exp_win);
        end

`ifdef TCDM_ARB_ERR_CNT_EN
        chk("err_cnt after one error", 32'(err_cnt_o), 32'd1);
`else
        chk("err_cnt tied off", 32'(err_cnt_o), 32'd0);
`endif

        // Stall with master 0 also requesting (ptr=1): master 2 held 3 cycles.
        for (int c = 0; c < 3; c++) begin
            drive(0, 4'b0101, 0, 0, 0, 32'h0);
            chk($sformatf("stall%0d s_add", c), s_add_o, 32'h1C00_0010);
            chk($sformatf("stall%0d m_gnt", c), 32'(m_gnt_o), 32'h0);
        end
        drive(0, 4'b0101, 1, 0, 0, 32'h0);
        chk("stall release s_add", s_add_o, 32'h1C00_0010);
        chk("stall release m_gnt", 32'(m_gnt_o), 32'b0100);
        drive(0, 4'b0101, 1, 1, 0, 32'h0);
        chk("after stall m_gnt", 32'(m_gnt_o), 32'b0001);
        chk("after stall m_rvalid", 32'(m_r_valid_o), 32'b0100);
        drive(0, 4'b0000, 0, 1, 0, 32'h0);
        chk("after stall rsp m0", 32'(m_r_valid_o), 32'b0001);

        // Reset right after a handshake to master 3 (ptr=1 here).
        drive(0, 4'b1000, 1, 0, 0, 32'h0);
        chk("pre-reset m_gnt", 32'(m_gnt_o), 32'b1000);
        drive(1, 4'b1111, 1, 1, 0, 32'h0);
        chk("in-reset m_gnt", 32'(m_gnt_o), 32'h0);
        chk("in-reset m_rvalid", 32'(m_r_valid_o), 32'h0);
        chk("in-reset s_req", 32'(s_req_o), 32'h1);
        drive(0, 4'b1111, 1, 1, 0, 32'h0);
        chk("post-reset m_gnt", 32'(m_gnt_o), 32'b0001);
        chk("post-reset m_rvalid", 32'(m_r_valid_o), 32'h0);
        chk("post-reset err_cnt", 32'(err_cnt_o), 32'h0);
        drive(0, 4'b1111, 1, 1, 0, 32'h0);
        chk("post-reset 2nd m_gnt", 32'(m_gnt_o), 32'b0010);
        chk("post-reset rsp m0", 32'(m_r_valid_o), 32'b0001);

`ifdef TCDM_ARB_ERR_CNT_EN
        // Error response every cycle, well past 65535.
        for (int c = 0; c < 65540; c++) drive(0, 4'b0001, 1, 1, 1, 32'h0);
        chk("err_cnt saturate", 32'(err_cnt_o), 32'h0000_FFFF);
`endif

        drive(0, 4'b0000, 0, 0, 0, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tcdm_rr_arbiter.md
TCDM_RR_ARBITER -- requirements
Module: tcdm_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting TCDM masters (2..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width; byte-enable width is DATA_WIDTH/8.
REQ-004 SHALL have port clk_i, input, 1, sole clock; all logic is rising-edge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports m_req_i, m_wen_i, input, NUM_MASTERS, per-master request and write-enable (1 = read, 0 = write).
REQ-007 SHALL have ports m_add_i, m_wdata_i, m_be_i, input, NUM_MASTERS x ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8, per-master payload.
REQ-008 SHALL have ports m_gnt_o, m_r_valid_o, output, NUM_MASTERS, per-master grant and response valid.
REQ-009 SHALL have ports m_r_rdata_o (DATA_WIDTH) and m_r_opc_o (1), output, response data and error flag broadcast to all masters.
REQ-010 SHALL have ports s_req_o, s_wen_o, s_add_o, s_wdata_o, s_be_o, output, request to the single shared TCDM slave.
REQ-011 SHALL have ports s_gnt_i, s_r_valid_i, s_r_rdata_i, s_r_opc_i, input, slave grant and response.
REQ-012 SHALL have port err_cnt_o, output, 16, count of error responses (see Configuration).

Function
REQ-013 Round-robin arbitration: a priority pointer ptr_q (log2 NUM_MASTERS bits) names the highest-priority master; the winner is the first requesting index at or after ptr_q, wrapping from NUM_MASTERS-1 to 0.
REQ-014 s_req_o SHALL be 1 iff any m_req_i bit is 1; s_add_o/s_wen_o/s_wdata_o/s_be_o SHALL be the winner's payload, combinationally, in the same cycle.
REQ-015 m_gnt_o[i] SHALL be s_gnt_i AND (winner == i); all other grants 0; at most one grant per cycle.
REQ-016 Handshake = s_req_o AND s_gnt_i; on handshake ptr_q SHALL become winner+1 (mod NUM_MASTERS) in the next cycle.
REQ-017 Stall lock: if s_req_o=1 and s_gnt_i=0, the winner SHALL be registered into lock_q and the selection SHALL remain that master in following cycles until its handshake, regardless of new higher-priority requests; lock clears on handshake.
REQ-018 Response routing: on handshake the winner index SHALL be registered into rsp_id_q; the slave responds with fixed latency 1; m_r_valid_o[rsp_id_q] SHALL equal s_r_valid_i, all others 0.
REQ-019 m_r_rdata_o SHALL equal s_r_rdata_i and m_r_opc_o SHALL equal s_r_opc_i, unregistered.
REQ-020 Back-to-back handshakes on consecutive cycles SHALL be supported with no bubble; responses return in grant order, one per cycle.
REQ-021 s_r_valid_i without a handshake in the prior cycle SHALL be dropped (no m_r_valid_o asserted).
REQ-022 A master that drops m_req_i while locked is illegal; simulation-only assertion SHALL flag it; RTL behaviour is then: lock released, normal arbitration resumes.

Reset
REQ-023 rst_i SHALL clear ptr_q to 0, lock_q to unlocked, rsp_id_q to 0, response-pending flag to 0, err_cnt_o to 0.
REQ-024 During rst_i all m_gnt_o and m_r_valid_o SHALL be 0; s_req_o remains combinational from m_req_i.
REQ-025 Reset mid-transaction SHALL discard any pending response (the following-cycle s_r_valid_i is dropped).

Configuration
REQ-026 Macro TCDM_ARB_ERR_CNT_EN: when defined, err_cnt_o SHALL increment by 1 each cycle m_r_valid_o is asserted with s_r_opc_i=1, saturating at 16'hFFFF; when undefined, err_cnt_o SHALL be tied to 0 and no counter is built.

Verification
REQ-027 NUM_MASTERS=4, all m_req_i=4'b1111, s_gnt_i=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; each m_r_valid_o one cycle after its grant.
REQ-028 Master 2 requests add=32'h1C00_0010, s_gnt_i=0 for 3 cycles while master 0 also requests -> s_add_o stays 32'h1C00_0010, m_gnt_o=4'b0100 when s_gnt_i rises, then master 0 granted.
REQ-029 Master 1 read, slave returns 32'hBADACCE5 with s_r_opc_i=1 -> m_r_valid_o=4'b0010, m_r_rdata_o=32'hBADACCE5, m_r_opc_o=1; err_cnt_o=1 with TCDM_ARB_ERR_CNT_EN, 0 without.
REQ-030 Spurious s_r_valid_i=1 with no prior handshake -> m_r_valid_o=4'b0000, err_cnt_o unchanged.
REQ-031 Assert rst_i one cycle after a handshake to master 3 -> m_r_valid_o=0 next cycle, ptr_q=0, next all-request grant goes to master 0.
REQ-032 Force 65536 error responses with TCDM_ARB_ERR_CNT_EN -> err_cnt_o saturates at 16'hFFFF.
